serial_rx_sequencer: RTL and testbench

Receive-side controller for the serial-to-parallel shifter datapath. It synchronises the raw serial line, detects and validates a start bit, and issues one shift strobe per data bit at the bit centre. It checks the stop bit, then issues a single load strobe that moves the assembled word into the parallel register. A valid/ready handshake is provided toward the consumer, and the block flags framing errors and overruns.

---
 rtl/serial_rx_sequencer.sv | 163 ++++++++++++++++
 tb/tb_serial_rx_sequencer.sv | 391 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_rx_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : serial_rx_sequencer
// Description : UART-style receive controller. It drives shift/load strobes
//               into an external serial-to-parallel shifter and provides a
//               valid/ready handshake with framing-error and overrun flags.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_rx_sequencer #(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_BITS    = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic serin,
    output logic shift_en,
    output logic shift_bit,
    output logic load,
    output logic rx_valid,
    input  logic rx_ready,
    output logic busy,
    output logic frame_err,
    output logic overrun
);

    localparam int c_BAUD_W = $clog2(CLKS_PER_BIT);
    localparam int c_BIT_W  = $clog2(DATA_BITS + 1);

    localparam logic [c_BAUD_W-1:0] c_BAUD_HALF = c_BAUD_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [c_BAUD_W-1:0] c_BAUD_LAST = c_BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [c_BIT_W-1:0]  c_BIT_LAST  = c_BIT_W'(DATA_BITS - 1);

    localparam logic [2:0] c_ST_IDLE  = 3'd0;
    localparam logic [2:0] c_ST_START = 3'd1;
    localparam logic [2:0] c_ST_DATA  = 3'd2;
    localparam logic [2:0] c_ST_STOP  = 3'd3;
    localparam logic [2:0] c_ST_BREAK = 3'd4;

    logic                r_sync1;
    logic                r_serin_s;
    logic [2:0]          r_state;
    logic [c_BAUD_W-1:0] r_baud;
    logic [c_BIT_W-1:0]  r_bits;
    logic                r_shift_en;
    logic                r_shift_bit;
    logic                r_load;
    logic                r_rx_valid;
    logic                r_busy;
    logic                r_frame_err;
    logic                r_overrun;

    logic [2:0]          w_state_nxt;
    logic [c_BAUD_W-1:0] w_baud_nxt;
    logic [c_BIT_W-1:0]  w_bits_nxt;
    logic                w_shift_en_nxt;
    logic                w_shift_bit_nxt;
    logic                w_load_nxt;
    logic                w_rx_valid_nxt;
    logic                w_frame_err_nxt;
    logic                w_overrun_nxt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1     <= 1'b1;
            r_serin_s   <= 1'b1;
            r_state     <= c_ST_IDLE;
            r_baud      <= '0;
            r_bits      <= '0;
            r_shift_en  <= 1'b0;
            r_shift_bit <= 1'b0;
            r_load      <= 1'b0;
            r_rx_valid  <= 1'b0;
            r_busy      <= 1'b0;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_sync1     <= serin;
            r_serin_s   <= r_sync1;
            r_state     <= w_state_nxt;
            r_baud      <= w_baud_nxt;
            r_bits      <= w_bits_nxt;
            r_shift_en  <= w_shift_en_nxt;
            r_shift_bit <= w_shift_bit_nxt;
            r_load      <= w_load_nxt;
            r_rx_valid  <= w_rx_valid_nxt;
            r_busy      <= (w_state_nxt != c_ST_IDLE);
            r_frame_err <= w_frame_err_nxt;
            r_overrun   <= w_overrun_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_baud_nxt      = r_baud + c_BAUD_W'(1);
        w_bits_nxt      = r_bits;
        w_shift_en_nxt  = 1'b0;
        w_shift_bit_nxt = r_shift_bit;
        w_load_nxt      = 1'b0;
        w_rx_valid_nxt  = r_rx_valid & ~rx_ready;
        w_frame_err_nxt = 1'b0;
        w_overrun_nxt   = 1'b0;

        case (r_state)
            c_ST_IDLE: begin
                w_baud_nxt = '0;
                if (!r_serin_s) w_state_nxt = c_ST_START;
            end
            c_ST_START: begin
                // A line that is high again at mid start bit was a glitch.
                if (r_baud == c_BAUD_HALF)
                    w_state_nxt = r_serin_s ? c_ST_IDLE : c_ST_DATA;
            end
            c_ST_DATA: begin
                if (r_baud == c_BAUD_LAST) begin
                    w_baud_nxt      = '0;
                    w_shift_en_nxt  = 1'b1;
                    w_shift_bit_nxt = r_serin_s;
                    w_bits_nxt      = r_bits + c_BIT_W'(1);
                    if (r_bits == c_BIT_LAST) w_state_nxt = c_ST_STOP;
                end
            end
            c_ST_STOP: begin
                if (r_baud == c_BAUD_LAST) begin
                    if (r_serin_s) begin
                        w_state_nxt = c_ST_IDLE;
                        // A word accepted in this very cycle frees the register.
                        if (!r_rx_valid || rx_ready) begin
                            w_load_nxt     = 1'b1;
                            w_rx_valid_nxt = 1'b1;
                        end else begin
                            w_overrun_nxt  = 1'b1;
                        end
                    end else begin
                        w_frame_err_nxt = 1'b1;
                        w_state_nxt     = c_ST_BREAK;
                    end
                end
            end
            c_ST_BREAK: begin
                w_baud_nxt = '0;
                if (r_serin_s) w_state_nxt = c_ST_IDLE;
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
            end
        endcase

        if (w_state_nxt != r_state) begin
            w_baud_nxt = '0;
            w_bits_nxt = '0;
        end
    end

    assign shift_en  = r_shift_en;
    assign shift_bit = r_shift_bit;
    assign load      = r_load;
    assign rx_valid  = r_rx_valid;
    assign busy      = r_busy;
    assign frame_err = r_frame_err;
    assign overrun   = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_serial_rx_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_rx_sequencer
// Description : Directed self-checking bench for serial_rx_sequencer with a
//               behavioural model of the downstream shifter/parallel register.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_rx_sequencer;

    localparam int CLKS = 4;
    localparam int NBITS = 8;
    // Strobe latency from the serin falling edge: 3 cycles to START, then
    // half a bit, then whole bits; +1 for the negedge sample index.
    localparam int STOP_OFS = 3 + CLKS / 2 + NBITS * CLKS + CLKS + 1;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic serin = 1'b1;
    logic rx_ready = 1'b0;
    logic shift_en, shift_bit, load, rx_valid, busy, frame_err, overrun;

    int checks = 0;
    int failures = 0;

    int cyc = 0;
    int nshift = 0;
    int nload = 0;
    int nfe = 0;
    int novr = 0;
    int nmutex = 0;
    int load_cyc = 0;
    int fe_cyc = 0;
    int ovr_cyc = 0;
    logic       sh_bits [0:255];
    int         sh_cyc  [0:255];
    logic [7:0] sreg = 8'h00;
    logic [7:0] preg = 8'h00;

    serial_rx_sequencer #(
        .CLKS_PER_BIT (CLKS),
        .DATA_BITS    (NBITS)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .serin     (serin),
        .shift_en  (shift_en),
        .shift_bit (shift_bit),
        .load      (load),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .busy      (busy),
        .frame_err (frame_err),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    // Downstream shifter model plus strobe bookkeeping, sampled mid-cycle.
    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (shift_en) begin
            sh_bits[nshift[7:0]] <= shift_bit;
            sh_cyc[nshift[7:0]]  <= cyc + 1;
            nshift <= nshift + 1;
            sreg   <= {sreg[6:0], shift_bit};
        end
        if (load) begin
            nload    <= nload + 1;
            load_cyc <= cyc + 1;
            preg     <= sreg;
        end
        if (frame_err) begin
            nfe    <= nfe + 1;
            fe_cyc <= cyc + 1;
        end
        if (overrun) begin
            novr    <= novr + 1;
            ovr_cyc <= cyc + 1;
        end
        if ($countones({shift_en, load, frame_err, overrun}) > 1) nmutex <= nmutex + 1;
    end

    task automatic drive_bit(input logic b);
        serin = b;
        repeat (CLKS) @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        serin = 1'b1;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] data, input logic stopb, output int t0);
        t0 = cyc;
        drive_bit(1'b0);
        for (int i = 7; i >= 0; i--) drive_bit(data[i]);
        drive_bit(stopb);
    endtask

    task automatic test_reset;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({shift_en, load, frame_err, overrun, shift_bit, rx_valid, busy} !== 7'b0) begin
            failures++;
            $display("FAIL reset_outputs got=%b exp=0000000",
                     {shift_en, load, frame_err, overrun, shift_bit, rx_valid, busy});
        end
        @(posedge clk);
        #1 reset = 1'b0;
        idle(3);
    endtask

    task automatic test_nominal;
        int b_sh, b_ld, t0;
        logic [7:0] d;
        d = 8'hA5;
        b_sh = nshift;
        b_ld = nload;
        send_frame(d, 1'b1, t0);
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (nshift - b_sh !== 8) begin
            failures++;
            $display("FAIL nominal_shift_count got=%0d exp=8", nshift - b_sh);
        end
        for (int k = 0; k < 8; k++) begin
            checks++;
            if (sh_bits[b_sh + k] !== d[7-k]) begin
                failures++;
                $display("FAIL nominal_bit%0d got=%b exp=%b", k, sh_bits[b_sh + k], d[7-k]);
            end
            checks++;
            if (sh_cyc[b_sh + k] !== t0 + 3 + CLKS / 2 + (k + 1) * CLKS + 1) begin
                failures++;
                $display("FAIL nominal_bit%0d_time got=%0d exp=%0d", k, sh_cyc[b_sh + k] - t0,
                         3 + CLKS / 2 + (k + 1) * CLKS + 1);
            end
        end
        checks++;
        if (nload - b_ld !== 1 || load_cyc !== t0 + STOP_OFS) begin
            failures++;
            $display("FAIL nominal_load got=%0d@%0d exp=1@%0d", nload - b_ld, load_cyc - t0, STOP_OFS);
        end
        checks++;
        if (preg !== 8'hA5) begin
            failures++;
            $display("FAIL nominal_word got=%h exp=a5", preg);
        end
        checks++;
        if (rx_valid !== 1'b1) begin
            failures++;
            $display("FAIL nominal_rx_valid got=%b exp=1", rx_valid);
        end
        rx_ready = 1'b1;
        @(posedge clk);
        #1 rx_ready = 1'b0;
        checks++;
        if (rx_valid !== 1'b0) begin
            failures++;
            $display("FAIL nominal_accept got=%b exp=0", rx_valid);
        end
        idle(4);
    endtask

    task automatic test_glitch;
        int b_sh, b_ld, busy_cnt;
        b_sh = nshift;
        b_ld = nload;
        busy_cnt = 0;
        serin = 1'b0;
        @(posedge clk);
        #1 serin = 1'b1;
        repeat (12) begin
            @(negedge clk);
            if (busy === 1'b1) busy_cnt++;
        end
        @(posedge clk);
        #1;
        checks++;
        if (busy_cnt !== 2) begin
            failures++;
            $display("FAIL glitch_busy_cycles got=%0d exp=2", busy_cnt);
        end
        checks++;
        if (nshift !== b_sh || nload !== b_ld) begin
            failures++;
            $display("FAIL glitch_strobes got=%0d/%0d exp=0/0", nshift - b_sh, nload - b_ld);
        end
    endtask

    task automatic test_frame_err;
        int b_sh, b_ld, b_fe, t0;
        b_sh = nshift;
        b_ld = nload;
        b_fe = nfe;
        send_frame(8'h3C, 1'b0, t0);
        repeat (3) drive_bit(1'b0);
        serin = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL break_busy_held got=%b exp=1", busy);
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL break_busy_release got=%b exp=0", busy);
        end
        @(posedge clk);
        #1;
        idle(20);
        checks++;
        if (nfe - b_fe !== 1 || fe_cyc !== t0 + STOP_OFS) begin
            failures++;
            $display("FAIL ferr_pulse got=%0d@%0d exp=1@%0d", nfe - b_fe, fe_cyc - t0, STOP_OFS);
        end
        checks++;
        if (nshift - b_sh !== 8 || nload !== b_ld) begin
            failures++;
            $display("FAIL ferr_strobes got=%0d/%0d exp=8/0", nshift - b_sh, nload - b_ld);
        end
        checks++;
        if (sreg !== 8'h3C || rx_valid !== 1'b0) begin
            failures++;
            $display("FAIL ferr_state got=%h/%b exp=3c/0", sreg, rx_valid);
        end
    endtask

    task automatic test_overrun;
        int b_ld, b_ov, t0, t1;
        b_ld = nload;
        b_ov = novr;
        send_frame(8'h11, 1'b1, t0);
        idle(4);
        send_frame(8'h22, 1'b1, t1);
        idle(4);
        checks++;
        if (nload - b_ld !== 1) begin
            failures++;
            $display("FAIL overrun_loads got=%0d exp=1", nload - b_ld);
        end
        checks++;
        if (novr - b_ov !== 1 || ovr_cyc !== t1 + STOP_OFS) begin
            failures++;
            $display("FAIL overrun_pulse got=%0d@%0d exp=1@%0d", novr - b_ov, ovr_cyc - t1, STOP_OFS);
        end
        checks++;
        if (preg !== 8'h11 || sreg !== 8'h22 || rx_valid !== 1'b1) begin
            failures++;
            $display("FAIL overrun_hold got=%h/%h/%b exp=11/22/1", preg, sreg, rx_valid);
        end
    endtask

    task automatic test_simultaneous;
        int b_ld, b_ov, t0;
        b_ld = nload;
        b_ov = novr;
        send_frame(8'h7E, 1'b1, t0);
        rx_ready = 1'b1;
        @(posedge clk);
        #1 rx_ready = 1'b0;
        @(negedge clk);
        checks++;
        if ({load, overrun, rx_valid} !== 3'b101) begin
            failures++;
            $display("FAIL simul_strobes got=%b exp=101 (load,overrun,rx_valid)", {load, overrun, rx_valid});
        end
        @(posedge clk);
        #1;
        checks++;
        if (preg !== 8'h7E || nload - b_ld !== 1 || novr !== b_ov) begin
            failures++;
            $display("FAIL simul_word got=%h/%0d/%0d exp=7e/1/0", preg, nload - b_ld, novr - b_ov);
        end
        rx_ready = 1'b1;
        @(posedge clk);
        #1 rx_ready = 1'b0;
        checks++;
        if (rx_valid !== 1'b0) begin
            failures++;
            $display("FAIL simul_accept got=%b exp=0", rx_valid);
        end
        idle(4);
    endtask

    task automatic test_reset_midframe;
        int b_sh, b_ld, t0, n;
        b_sh = nshift;
        drive_bit(1'b0);
        repeat (4) drive_bit(1'b1);
        serin = 1'b0;
        n = 0;
        while (nshift - b_sh < 4 && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        checks++;
        if (n >= 40) begin
            failures++;
            $display("FAIL midframe_wait got=%0d exp=4 shifts", nshift - b_sh);
        end
        reset = 1'b1;
        serin = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        checks++;
        if ({shift_en, load, frame_err, overrun, shift_bit, rx_valid, busy} !== 7'b0) begin
            failures++;
            $display("FAIL midframe_reset got=%b exp=0000000",
                     {shift_en, load, frame_err, overrun, shift_bit, rx_valid, busy});
        end
        idle(8);
        checks++;
        if (nshift - b_sh !== 4) begin
            failures++;
            $display("FAIL midframe_discard got=%0d exp=4", nshift - b_sh);
        end
        b_sh = nshift;
        b_ld = nload;
        send_frame(8'h81, 1'b1, t0);
        idle(2);
        checks++;
        if (nshift - b_sh !== 8 || nload - b_ld !== 1 || preg !== 8'h81 || load_cyc !== t0 + STOP_OFS) begin
            failures++;
            $display("FAIL midframe_recover got=%0d/%0d/%h@%0d exp=8/1/81@%0d",
                     nshift - b_sh, nload - b_ld, preg, load_cyc - t0, STOP_OFS);
        end
        rx_ready = 1'b1;
        @(posedge clk);
        #1 rx_ready = 1'b0;
    endtask

    task automatic test_back_to_back;
        int b_sh, b_ld, t0, t1;
        b_sh = nshift;
        b_ld = nload;
        rx_ready = 1'b1;
        send_frame(8'h5A, 1'b1, t0);
        send_frame(8'hC3, 1'b1, t1);
        idle(2);
        checks++;
        if (preg !== 8'hC3 || nload - b_ld !== 2 || load_cyc !== t1 + STOP_OFS) begin
            failures++;
            $display("FAIL b2b_second got=%h/%0d@%0d exp=c3/2@%0d", preg, nload - b_ld, load_cyc - t1, STOP_OFS);
        end
        checks++;
        if (nshift - b_sh !== 16 || sh_cyc[b_sh + 8] !== t1 + 3 + CLKS / 2 + CLKS + 1) begin
            failures++;
            $display("FAIL b2b_timing got=%0d@%0d exp=16@%0d", nshift - b_sh, sh_cyc[b_sh + 8] - t1,
                     3 + CLKS / 2 + CLKS + 1);
        end
        rx_ready = 1'b0;
        idle(2);
        checks++;
        if (rx_valid !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL b2b_idle got=%b/%b exp=0/0", rx_valid, busy);
        end
    endtask

    task automatic test_exclusion;
        checks++;
        if (nmutex !== 0) begin
            failures++;
            $display("FAIL strobe_exclusion got=%0d exp=0", nmutex);
        end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_glitch();
        test_frame_err();
        test_overrun();
        test_simultaneous();
        test_reset_midframe();
        test_back_to_back();
        test_exclusion();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
